// File: rtl/seg7_pkg.sv
// seg7_pkg: segment encodings, scan FSM states and slot-length derivation for seg7_scan_ctrl.
package seg7_pkg;
  typedef enum logic {SHOW, DEAD} state_t;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  function automatic int digit_cycles(int clk_hz, int refresh_hz);
    return clk_hz / (2 * refresh_hz);
  endfunction
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational nibble to 7-segment (GFEDCBA, active-high) decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG_TAB[nib];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: dual-digit 7-segment scan with dead-time blanking, PWM and frame-aligned updates.
// Define SEG7_BLANK_LZ_EN to blank the high digit when its nibble is zero.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_HZ          = 48_000_000,
  parameter int REFRESH_HZ      = 1000,
  parameter int DEADTIME_CYCLES = 48,
  parameter int BRIGHT_W        = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [7:0]          i_data,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [BRIGHT_W-1:0] i_brightness,
  output logic [6:0]          o_segments,
  output logic                o_digit
);
  localparam int DIGIT_CYCLES = digit_cycles(CLK_HZ, REFRESH_HZ);
  localparam int SHOW_CYCLES  = DIGIT_CYCLES - DEADTIME_CYCLES;
  localparam int CW           = $clog2(DIGIT_CYCLES + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic digit, digit_nx, last, boundary, hs, pwm_on, lz, pend_valid;
  logic [BRIGHT_W-1:0] pwm_cnt;
  logic [7:0] disp, pend;
  logic [3:0] nib;
  logic [6:0] dec, seg_nx;
  always_comb begin
    last     = 1'b0;
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    digit_nx = digit;
    last     = cnt == (state == SHOW ? CW'(SHOW_CYCLES - 1) : CW'(DEADTIME_CYCLES - 1));
    state_nx = last ? (state == SHOW ? DEAD : SHOW) : state;
    cnt_nx   = last ? '0 : cnt + 1'b1;
    digit_nx = (last && state == DEAD) ? ~digit : digit;
  end
  // the frame ends after the high digit's dead time; only then may the displayed byte change
  assign boundary = state == DEAD && last && digit;
  assign o_ready  = ~pend_valid;
  assign hs       = i_valid && o_ready;
  assign pwm_on   = (pwm_cnt < i_brightness) || (&i_brightness);
  assign nib      = digit ? disp[7:4] : disp[3:0];
`ifdef SEG7_BLANK_LZ_EN
  assign lz = digit && disp[7:4] == 4'h0;
`else
  assign lz = 1'b0;
`endif
  hex_to_seg7 u_dec (.nib(nib), .seg(dec));
  assign seg_nx = (state == SHOW && pwm_on && !lz) ? dec : '0;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= SHOW;
      cnt        <= '0;
      digit      <= 1'b0;
      pwm_cnt    <= '0;
      o_segments <= '0;
      o_digit    <= 1'b0;
      disp       <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      digit      <= digit_nx;
      pwm_cnt    <= pwm_cnt + 1'b1;
      o_segments <= seg_nx;
      o_digit    <= digit;
      if (boundary && pend_valid) begin
        disp       <= pend;
        pend_valid <= 1'b0;
      end else if (boundary && hs) begin
        disp <= i_data;
      end else if (hs) begin
        pend       <= i_data;
        pend_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed and random stimulus checked every cycle against a frame-level model.
module tb_seg7_scan_ctrl;
  localparam int DIG = 20;
  localparam int DT  = 4;
  localparam int SHW = DIG - DT;
  localparam logic [6:0] TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  logic clk = 0, rst_n = 0, valid = 0, ready, dig;
  logic [7:0] data = 0;
  logic [3:0] bright = 4'hF;
  logic [6:0] seg;
  int errors = 0, checks = 0;
  int k;
  logic [7:0] disp_m;
  logic [7:0] pend_q [$];
  logic [6:0] exp_seg;
  logic exp_dig, acc, m_hs, m_lz, m_high;
  logic [3:0] m_nib;
  always #5 clk = ~clk;
  seg7_scan_ctrl #(.CLK_HZ(1600), .REFRESH_HZ(40), .DEADTIME_CYCLES(DT), .BRIGHT_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .o_ready(ready),
    .i_brightness(bright), .o_segments(seg), .o_digit(dig)
  );
  // model: output in cycle k+1 reflects scan position, PWM phase and byte of cycle k
  always @(posedge clk) begin
    if (!rst_n) begin
      k = 0; disp_m = 8'h00; pend_q.delete(); exp_seg = 0; exp_dig = 0; acc = 0;
    end else begin
      m_hs   = valid && pend_q.size() == 0;
      m_high = ((k / DIG) % 2) == 1;
      m_nib  = m_high ? disp_m[7:4] : disp_m[3:0];
`ifdef SEG7_BLANK_LZ_EN
      m_lz = m_high && disp_m[7:4] == 4'h0;
`else
      m_lz = 1'b0;
`endif
      exp_dig = m_high;
      exp_seg = ((k % DIG) < SHW && (bright == 4'hF || (k % 16) < int'(bright)) && !m_lz) ? TAB[m_nib] : 7'h00;
      if (k % (2 * DIG) == 2 * DIG - 1) begin
        if (pend_q.size() != 0) disp_m = pend_q.pop_front();
        else if (m_hs) disp_m = data;
      end else if (m_hs) pend_q.push_back(data);
      acc = m_hs;
      k++;
    end
  end
  task automatic check(string tag);
    checks += 3;
    assert (seg === exp_seg) else begin
      errors++; $error("FAIL %s seg k=%0d got=%h exp=%h", tag, k, seg, exp_seg);
    end
    assert (dig === exp_dig) else begin
      errors++; $error("FAIL %s digit k=%0d got=%b exp=%b", tag, k, dig, exp_dig);
    end
    assert (ready === (pend_q.size() == 0)) else begin
      errors++; $error("FAIL %s ready k=%0d got=%b exp=%b", tag, k, ready, pend_q.size() == 0);
    end
  endtask
  task automatic tick(string tag);
    @(posedge clk);
    @(negedge clk);
    check(tag);
  endtask
  task automatic run(int n, string tag);
    repeat (n) tick(tag);
  endtask
  task automatic send(logic [7:0] d, string tag);
    int n = 0;
    valid = 1; data = d;
    do begin tick(tag); n++; end while (!acc && n < 300);
    checks++;
    assert (acc) else begin
      errors++; $error("FAIL %s handshake timeout got=%b exp=1", tag, acc);
    end
    valid = 0; data = 8'($urandom);
  endtask
  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    check("reset");
    run(100, "idle");
    send(8'hA5, "a5");
    run(100, "a5");
    send(8'h12, "h12");
    send(8'h34, "h34");
    run(120, "h34");
    bright = 4'h0;
    run(80, "dark");
    bright = 4'h8;
    run(80, "half");
    bright = 4'hF;
    send(8'h07, "h07");
    run(100, "h07");
    for (int i = 0; i < 8; i++) begin
      bright = 4'($urandom);
      valid = 0;
      send(8'($urandom), "rand");
      run(int'($urandom_range(5, 60)), "rand");
    end
    bright = 4'hF;
    send(8'h9C, "pre_rst");
    run(60, "pre_rst");
    n = 0;
    while (!(exp_dig && (k % DIG) > 2 && (k % DIG) < SHW - 2) && n < 100) begin
      tick("seek"); n++;
    end
    #2 rst_n = 0;
    #1;
    checks += 3;
    assert (seg === 7'h00) else begin errors++; $error("FAIL async_rst seg got=%h exp=00", seg); end
    assert (dig === 1'b0) else begin errors++; $error("FAIL async_rst digit got=%b exp=0", dig); end
    assert (ready === 1'b1) else begin errors++; $error("FAIL async_rst ready got=%b exp=1", ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    check("post_rst");
    run(90, "post_rst");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
